panel_switch_reader: RTL and testbench
======================================

# panel_switch_reader

Front-panel switch input block: samples up to WIDTH active-low toggle/push switches, which are wired to ground with board pull-ups, and synchronizes them into CLK. Each switch is debounced independently into a clean active-high level. The block emits single-cycle press and release pulses. It is the input-side counterpart of the panel LED indicators and feeds the single-step, run/halt and data-entry logic.

## Interface
Parameters:
- WIDTH, 8, number of switch channels (1..32)
- DEBOUNCE_CYCLES, 16, consecutive agreeing synchronized samples required before a channel's state flips (≥1)

Ports:
- CLK  input  1  single system clock; all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- SW_N  input  WIDTH  raw switch pins, active-low (0 = closed), asynchronous to CLK
- STATE  output  WIDTH  debounced level, active-high (1 = closed)
- PRESS  output  WIDTH  one-cycle pulse per channel on STATE 0→1
- RELEASE  output  WIDTH  one-cycle pulse per channel on STATE 1→0
- CHANGED  output  1  OR of all PRESS and RELEASE bits, same cycle

## Operation
- Synchronizer: two flops per channel, s1 ← ~SW_N, then s2 ← s1. s2 is the synchronized active-high sample. No other logic reads s1.
- Per-channel counter `cnt`, width $clog2(DEBOUNCE_CYCLES+1):
  - s2 == STATE: cnt ← 0.
  - s2 != STATE and cnt < DEBOUNCE_CYCLES−1: cnt ← cnt+1.
  - s2 != STATE and cnt == DEBOUNCE_CYCLES−1: STATE ← s2, cnt ← 0, and PRESS (if s2=1) or RELEASE (if s2=0) ← 1.
- PRESS and RELEASE are registered. They are high for exactly one cycle following the flip edge and 0 otherwise.
- A glitch shorter than DEBOUNCE_CYCLES synchronized samples resets cnt and produces no output change.
- Channels are fully independent. Simultaneous flips on several channels assert several PRESS/RELEASE bits in the same cycle, with one CHANGED.
- PRESS and RELEASE of the same channel never assert together.
- Counters saturate by construction and never wrap.

## Timing
- Reset values: s1, s2, cnt, STATE, PRESS, RELEASE, CHANGED all 0. The zero state means every switch reads as released.
- Latency, with the raw edge sampled by s1 at edge k:
  - s2 updates at edge k+1.
  - STATE and the pulse update at edge k+1+DEBOUNCE_CYCLES.
  - Both are visible in the cycle after that edge.
- Switch held closed through reset: after RST drops, PRESS fires at the normal latency, counted from the first post-reset s1 sample.
- RST asserted mid-count: every channel returns to reset values at that edge. Any pulse pending or in flight is dropped.
- Minimum spacing between opposite pulses on one channel is DEBOUNCE_CYCLES cycles.

## Configuration
- Macro: PANEL_SW_DEBOUNCE_EN.
- Defined: debounce counters are instantiated as described, and DEBOUNCE_CYCLES is honoured.
- Not defined:
  - Counters are omitted and DEBOUNCE_CYCLES is ignored.
  - STATE ← s2 on every edge, with PRESS and RELEASE derived from the STATE transition. This is identical to DEBOUNCE_CYCLES=1.
  - Latency is k+2.
  - Intended for simulation and for inputs already debounced on the board.

## Test plan
- Reset then idle: RST high 3 cycles, SW_N all 1 for 100 cycles → STATE=0 and no PRESS, RELEASE or CHANGED asserted at any point.
- Clean press, WIDTH=8, DEBOUNCE_CYCLES=16: SW_N[3] 1→0 before edge k → STATE[3]=1 and PRESS[3]=1 for one cycle after edge k+17, CHANGED=1 that cycle. Release then gives RELEASE[3] with the same latency.
- Bounce rejection: SW_N[0] toggles every 5 cycles for 60 cycles, then held 0 → a single PRESS[0], 17 cycles after the last toggle is sampled. No RELEASE[0] is seen.
- Simultaneous channels: SW_N[1] and SW_N[6] go low on the same cycle → PRESS=8'h42 for one cycle and CHANGED=1 for one cycle.
- Reset mid-count: SW_N[2]=0, RST pulsed at count 10 → all outputs are 0 after the reset edge, and PRESS[2] arrives 17 edges after the first post-reset sample.
- Macro off: PANEL_SW_DEBOUNCE_EN undefined, SW_N[5] 1→0 at edge k → PRESS[5] after edge k+2. A one-cycle glitch produces a PRESS/RELEASE pair.

Source files
------------

// File: rtl/panel_switch_reader_if.sv
// Switch-panel bundle: raw active-low pins in, debounced level and edge pulses out.
interface panel_switch_reader_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] SW_N;
    logic [WIDTH-1:0] STATE;
    logic [WIDTH-1:0] PRESS;
    logic [WIDTH-1:0] RELEASE;
    logic             CHANGED;

    modport master (output SW_N, input STATE, PRESS, RELEASE, CHANGED);
    modport slave  (input SW_N, output STATE, PRESS, RELEASE, CHANGED);
endinterface

// File: rtl/panel_switch_reader.sv
// Front-panel switch reader: 2-flop sync, per-channel debounce, press/release pulses.
// Debounce counters exist only when PANEL_SW_DEBOUNCE_EN is defined; otherwise STATE follows s2.
module panel_switch_reader #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input logic                  CLK,
    input logic                  RST,
    panel_switch_reader_if.slave sw
);
    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] state_q, press_q, release_q;
    logic             changed_q;
    logic [WIDTH-1:0] state_d, press_d, release_d;

`ifdef PANEL_SW_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q [WIDTH];
    logic [CntW-1:0] cnt_d [WIDTH];

    // Flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    state_d[i]   = s2_q[i];
                    press_d[i]   = s2_q[i];
                    release_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (RST) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;

    always_comb begin
        state_d   = s2_q;
        press_d   = s2_q & ~state_q;
        release_d = ~s2_q & state_q;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q      <= '0;
            s2_q      <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= ~sw.SW_N;
            s2_q      <= s1_q;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            changed_q <= |{press_d, release_d};
        end
    end

    assign sw.STATE   = state_q;
    assign sw.PRESS   = press_q;
    assign sw.RELEASE = release_q;
    assign sw.CHANGED = changed_q;

endmodule

// File: tb/tb_panel_switch_reader.sv
// Bench for panel_switch_reader: window-based reference model plus directed literal checks.
module tb_panel_switch_reader;
    localparam int unsigned W  = 8;
    localparam int unsigned DC = 16;
`ifdef PANEL_SW_DEBOUNCE_EN
    localparam int unsigned DEFF = DC;
`else
    localparam int unsigned DEFF = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    panel_switch_reader_if #(.WIDTH(W)) sw_if ();

    panel_switch_reader #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .sw  (sw_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: a channel flips when its last DEFF synchronized samples all disagree with it.
    logic [W-1:0]    m_s1, m_s2, m_state, m_press, m_rel;
    logic [DEFF-1:0] m_win [W];
    bit              m_live = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_state = '0; m_press = '0; m_rel = '0;
            for (int i = 0; i < int'(W); i++) m_win[i] = '0;
            m_live = 1;
        end else begin
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < int'(W); i++) begin
                m_win[i] = (m_win[i] << 1) | DEFF'(m_s2[i]);
                if (m_win[i] == {DEFF{~m_state[i]}}) begin
                    m_press[i] = ~m_state[i];
                    m_rel[i]   = m_state[i];
                    m_state[i] = ~m_state[i];
                end
            end
            m_s2 = m_s1;
            m_s1 = ~sw_if.SW_N;
        end
    end

    bit seen_out = 0;
    int p0 = 0, r0 = 0, p5 = 0, r5 = 0;

    always @(negedge clk) begin
        if (m_live) begin
            check("STATE",   32'(sw_if.STATE),   32'(m_state));
            check("PRESS",   32'(sw_if.PRESS),   32'(m_press));
            check("RELEASE", 32'(sw_if.RELEASE), 32'(m_rel));
            check("CHANGED", 32'(sw_if.CHANGED), 32'(|{m_press, m_rel}));
            if (|{sw_if.STATE, sw_if.PRESS, sw_if.RELEASE, sw_if.CHANGED}) seen_out = 1;
            if (sw_if.PRESS[0] === 1'b1)   p0++;
            if (sw_if.RELEASE[0] === 1'b1) r0++;
            if (sw_if.PRESS[5] === 1'b1)   p5++;
            if (sw_if.RELEASE[5] === 1'b1) r5++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_state"},   32'(sw_if.STATE),   32'h0);
        check({name, "_press"},   32'(sw_if.PRESS),   32'h0);
        check({name, "_release"}, 32'(sw_if.RELEASE), 32'h0);
        check({name, "_changed"}, 32'(sw_if.CHANGED), 32'h0);
    endtask

    initial begin
        sw_if.SW_N = '1;
        rst = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        seen_out = 0;
        tick(100);
        check("idle_quiet", 32'(seen_out), 32'h0);

        // Clean press and release on channel 3.
        sw_if.SW_N[3] = 1'b0;
        tick(1 + DEFF);
        check("press3_early", 32'(sw_if.PRESS), 32'h0);
        tick(1);
        check("press3_pulse", 32'(sw_if.PRESS), 32'h08);
        check("press3_state", 32'(sw_if.STATE), 32'h08);
        check("press3_chg",   32'(sw_if.CHANGED), 32'h1);
        tick(1);
        check("press3_one",   32'(sw_if.PRESS), 32'h0);
        check("press3_chg0",  32'(sw_if.CHANGED), 32'h0);
        tick(30);
        sw_if.SW_N[3] = 1'b1;
        tick(1 + DEFF);
        check("rel3_early", 32'(sw_if.RELEASE), 32'h0);
        tick(1);
        check("rel3_pulse", 32'(sw_if.RELEASE), 32'h08);
        check("rel3_state", 32'(sw_if.STATE), 32'h0);
        tick(30);

        // Bounce on channel 0: toggle every 5 cycles, finish held closed.
        p0 = 0; r0 = 0;
        for (int t = 0; t <= 12; t++) begin
            sw_if.SW_N[0] = ~sw_if.SW_N[0];
            if (t < 12) tick(5);
        end
        tick(1 + DEFF);
        check("bounce_early", 32'(sw_if.PRESS[0]), 32'h0);
        tick(1);
        check("bounce_press", 32'(sw_if.PRESS), 32'h01);
        tick(5);
`ifdef PANEL_SW_DEBOUNCE_EN
        check("bounce_npress", 32'(p0), 32'd1);
        check("bounce_nrel",   32'(r0), 32'd0);
`else
        check("bounce_npress", 32'(p0), 32'd7);
        check("bounce_nrel",   32'(r0), 32'd6);
`endif
        sw_if.SW_N[0] = 1'b1;
        tick(DEFF + 30);

        // Simultaneous presses on channels 1 and 6.
        sw_if.SW_N[1] = 1'b0;
        sw_if.SW_N[6] = 1'b0;
        tick(1 + DEFF);
        check("simul_early", 32'(sw_if.PRESS), 32'h0);
        tick(1);
        check("simul_press", 32'(sw_if.PRESS), 32'h42);
        check("simul_chg",   32'(sw_if.CHANGED), 32'h1);
        tick(1);
        check("simul_one",   32'(sw_if.PRESS), 32'h0);
        check("simul_chg0",  32'(sw_if.CHANGED), 32'h0);
        sw_if.SW_N[1] = 1'b1;
        sw_if.SW_N[6] = 1'b1;
        tick(DEFF + 30);

        // Reset mid-count on channel 2 (count 10 when the reset edge arrives).
        sw_if.SW_N[2] = 1'b0;
        tick(12);
        rst = 1'b1;
        tick(1);
        check_all_zero("midrst");
        rst = 1'b0;
        tick(1 + DEFF);
        check("midrst_early", 32'(sw_if.PRESS), 32'h0);
        tick(1);
        check("midrst_press", 32'(sw_if.PRESS), 32'h04);
        sw_if.SW_N[2] = 1'b1;
        tick(DEFF + 30);

        // One-cycle glitch on channel 5.
        p5 = 0; r5 = 0;
        sw_if.SW_N[5] = 1'b0;
        tick(1);
        sw_if.SW_N[5] = 1'b1;
        tick(DEFF + 30);
`ifdef PANEL_SW_DEBOUNCE_EN
        check("glitch_npress", 32'(p5), 32'd0);
        check("glitch_nrel",   32'(r5), 32'd0);
`else
        check("glitch_npress", 32'(p5), 32'd1);
        check("glitch_nrel",   32'(r5), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
